// File: rtl/ex_result_pipe.sv
// Execute-stage result select/word-extend plus a 2-entry skid buffer feeding MEM.
// in_ready comes from the state register only, so MEM back-pressure never reaches EX combinationally.
module ex_result_pipe #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        res_sel,
    input  logic              inst_word,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] shifter_res,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [RD_W-1:0]   rd_addr,
    input  logic              rd_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic [DATA_W-1:0] out_pc,
    output logic [RD_W-1:0]   out_rd_addr,
    output logic              out_rd_wen,
    output logic [1:0]        occupancy
);

    // Encodings equal the number of held entries.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] sel_res;
    logic [DATA_W-1:0] new_res;
    logic              new_wen;
    logic [DATA_W-1:0] skid_res;
    logic [DATA_W-1:0] skid_pc;
    logic [RD_W-1:0]   skid_rd_addr;
    logic              skid_rd_wen;
    logic              accept;
    logic              fire;

    always_comb begin
        sel_res = '0;
        case (res_sel)
            2'b00:   sel_res = alu_res;
            2'b01:   sel_res = shifter_res;
            2'b10:   sel_res = in_pc + DATA_W'(4);
            default: sel_res = '0;
        endcase
        // The shifter leaves the upper half unresolved for *W ops, so always rebuild it.
        if (inst_word)
            new_res = {{(DATA_W-32){sel_res[31]}}, sel_res[31:0]};
        else
            new_res = sel_res;
        new_wen = rd_wen & (rd_addr != '0);
    end

    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);
    assign occupancy = state;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_EMPTY;
            out_res      <= '0;
            out_pc       <= '0;
            out_rd_addr  <= '0;
            out_rd_wen   <= 1'b0;
            skid_res     <= '0;
            skid_pc      <= '0;
            skid_rd_addr <= '0;
            skid_rd_wen  <= 1'b0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state       <= S_ONE;
                        out_res     <= new_res;
                        out_pc      <= in_pc;
                        out_rd_addr <= rd_addr;
                        out_rd_wen  <= new_wen;
                    end
                end
                S_ONE: begin
                    if (accept && fire) begin
                        out_res     <= new_res;
                        out_pc      <= in_pc;
                        out_rd_addr <= rd_addr;
                        out_rd_wen  <= new_wen;
                    end else if (accept) begin
                        state        <= S_FULL;
                        skid_res     <= new_res;
                        skid_pc      <= in_pc;
                        skid_rd_addr <= rd_addr;
                        skid_rd_wen  <= new_wen;
                    end else if (fire) begin
                        state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (fire) begin
                        state       <= S_ONE;
                        out_res     <= skid_res;
                        out_pc      <= skid_pc;
                        out_rd_addr <= skid_rd_addr;
                        out_rd_wen  <= skid_rd_wen;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule
